hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter FLUSH_DEPTH, default 2: number of consecutive cycles flush_id is asserted per taken branch (legal range 1..3).
REQ-002 SHALL have the following ports, clock and reset first:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  decode stage holds a valid instruction.
- id_rs1  in  5  decode source register 1.
- id_rs2  in  5  decode source register 2.
- id_uses_rs1  in  1  instruction reads rs1.
- id_uses_rs2  in  1  instruction reads rs2.
- id_rd  in  5  decode destination register.
- id_rd_we  in  1  instruction writes rd.
- id_is_fpu  in  1  instruction is a multi-cycle FPU op.
- id_fpu_lat  in  3  FPU latency in cycles.
- ex_is_load  in  1  execute stage holds a load.
- ex_rd  in  5  execute stage destination register.
- branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold decode register.
- flush_id  out  1  squash decode-stage instruction.
- flush_ex  out  1  insert bubble into EX next cycle.
- fpu_issue  out  1  FPU op accepted this cycle.
- fpu_done  out  1  in-flight FPU op completes this cycle.
- fpu_rd  out  5  destination of the in-flight FPU op.

Function
REQ-003 SHALL assert load_use (internal, combinational) when ex_is_load, ex_rd!=0, id_valid, and (id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd).
REQ-004 SHALL keep a 32-bit pending scoreboard; bit 0 SHALL never be set.
REQ-005 SHALL assert fpu_raw when id_valid and a used source register has its pending bit set; fpu_waw when id_valid, id_rd_we, id_rd!=0 and pending[id_rd] is set.
REQ-006 SHALL keep a 3-bit fpu_cnt; busy = fpu_cnt!=0; free = fpu_cnt<=1.
REQ-007 SHALL assert fpu_struct when id_valid, id_is_fpu and not free.
REQ-008 SHALL set stall = load_use | fpu_raw | fpu_waw | fpu_struct, forced to 0 while branch_taken or flush_id is active.
REQ-009 SHALL drive stall_if = stall_id = stall, and flush_ex = stall | branch_taken, all combinationally in the same cycle.
REQ-010 SHALL assert fpu_issue when id_valid, id_is_fpu, free, not stall, not branch_taken and not flush_id.
REQ-011 On fpu_issue, SHALL load fpu_cnt with id_fpu_lat (0 treated as 1), capture fpu_rd=id_rd, and set pending[id_rd] if id_rd!=0.
REQ-012 While busy without a new issue, SHALL decrement fpu_cnt by 1 per cycle.
REQ-013 SHALL assert fpu_done combinationally when fpu_cnt==1, and clear pending[fpu_rd] at the end of that cycle.
REQ-014 For issue and done in the same cycle, SHALL accept the new issue back-to-back; if the new id_rd equals the completing fpu_rd, set SHALL win and the pending bit SHALL remain 1.
REQ-015 In the fpu_done cycle, SHALL still treat the completing register as pending for REQ-005; consumers stall one cycle longer.
REQ-016 On branch_taken, SHALL assert flush_id that cycle and load flush_cnt with FLUSH_DEPTH-1.
REQ-017 While flush_cnt!=0, SHALL assert flush_id and decrement flush_cnt; a branch_taken during this window SHALL reload flush_cnt.
REQ-018 An in-flight FPU op SHALL NOT be cancelled by branch_taken, since it is older than the branch.
REQ-019 An FPU op with id_rd==0 SHALL still occupy the unit and produce fpu_done.

Reset
REQ-020 While rst_n=0, SHALL asynchronously clear pending, fpu_cnt, flush_cnt and fpu_rd.
REQ-021 Reset SHALL force stall_if, stall_id, flush_id, flush_ex, fpu_issue and fpu_done to 0.
REQ-022 Reset mid-operation SHALL discard the in-flight FPU op; no fpu_done SHALL follow for it.

Verification
REQ-023 Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> stall_if=stall_id=flush_ex=1 for 1 cycle; with ex_rd=0 -> no stall.
REQ-024 FPU RAW: issue id_rd=7, id_fpu_lat=3 at cycle T; next instruction reads x7 -> fpu_done at T+3, stall through T+3, released at T+4.
REQ-025 Back-to-back FPU: second FPU op presented at T+1..T+2 stalls (fpu_struct); it issues at T+3 in the done cycle and fpu_cnt reloads.
REQ-026 Branch: branch_taken with FLUSH_DEPTH=2 while load_use is also true -> stall=0, flush_id=1 for 2 cycles, flush_ex=1 for 1 cycle, no fpu_issue.
REQ-027 Reset mid-op: rst_n=0 at T+1 after an issue with lat=5 -> pending=0, fpu_done never asserted, outputs 0 immediately.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use and FPU scoreboard stalls, branch flush window,
// and occupancy tracking for a single non-pipelined multi-cycle FPU.
module hazard_unit #(
  parameter int FLUSH_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_rd_we,
  input  logic       id_is_fpu,
  input  logic [2:0] id_fpu_lat,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  input  logic       branch_taken,
  output logic       stall_if,
  output logic       stall_id,
  output logic       flush_id,
  output logic       flush_ex,
  output logic       fpu_issue,
  output logic       fpu_done,
  output logic [4:0] fpu_rd
);

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_DEPTH - 1);

  logic [31:0] pending_q, pending_d;
  logic [2:0]  fpu_cnt_q, fpu_cnt_d;
  logic [4:0]  fpu_rd_q, fpu_rd_d;
  logic [1:0]  flush_cnt_q, flush_cnt_d;

  logic load_use, fpu_raw, fpu_waw, fpu_struct;
  logic fpu_busy, fpu_free;
  logic flush_act, stall, issue, done;

  assign fpu_busy = (fpu_cnt_q != 3'd0);
  assign fpu_free = (fpu_cnt_q <= 3'd1);
  assign done     = (fpu_cnt_q == 3'd1);

  assign load_use = ex_is_load && (ex_rd != 5'd0) && id_valid &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // The completing register is still marked in its done cycle, so its readers wait one more cycle.
  assign fpu_raw    = id_valid && ((id_uses_rs1 && pending_q[id_rs1]) ||
                                   (id_uses_rs2 && pending_q[id_rs2]));
  assign fpu_waw    = id_valid && id_rd_we && (id_rd != 5'd0) && pending_q[id_rd];
  assign fpu_struct = id_valid && id_is_fpu && !fpu_free;

  assign flush_act = branch_taken || (flush_cnt_q != 2'd0);
  assign stall     = (load_use || fpu_raw || fpu_waw || fpu_struct) && !flush_act;
  assign issue     = id_valid && id_is_fpu && fpu_free && !stall && !flush_act;

  // Outputs are held low for the whole reset interval, independent of the inputs.
  assign stall_if  = rst_n && stall;
  assign stall_id  = rst_n && stall;
  assign flush_id  = rst_n && flush_act;
  assign flush_ex  = rst_n && (stall || branch_taken);
  assign fpu_issue = rst_n && issue;
  assign fpu_done  = rst_n && done;
  assign fpu_rd    = fpu_rd_q;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path infers a latch.
    pending_d   = pending_q;
    fpu_cnt_d   = fpu_cnt_q;
    fpu_rd_d    = fpu_rd_q;
    flush_cnt_d = flush_cnt_q;

    // Clear before set: a back-to-back issue to the completing register keeps it pending.
    if (done) pending_d[fpu_rd_q] = 1'b0;
    if (issue && (id_rd != 5'd0)) pending_d[id_rd] = 1'b1;
    pending_d[0] = 1'b0;

    if (issue) begin
      fpu_cnt_d = (id_fpu_lat == 3'd0) ? 3'd1 : id_fpu_lat;
      fpu_rd_d  = id_rd;
    end else if (fpu_busy) begin
      fpu_cnt_d = fpu_cnt_q - 3'd1;
    end

    if (branch_taken) begin
      flush_cnt_d = FLUSH_RELOAD;
    end else if (flush_cnt_q != 2'd0) begin
      flush_cnt_d = flush_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      fpu_cnt_q   <= '0;
      fpu_rd_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
      pending_q   <= pending_d;
      fpu_cnt_q   <= fpu_cnt_d;
      fpu_rd_q    <= fpu_rd_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a cycle-indexed reference model predicts outputs,
// a negedge monitor compares them.
module tb_hazard_unit;

  localparam int FLUSH_DEPTH = 2;

  typedef struct packed {
    logic       id_valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] rd;
    logic       rd_we;
    logic       is_fpu;
    logic [2:0] lat;
    logic       ex_is_load;
    logic [4:0] ex_rd;
    logic       br;
  } stim_t;

  typedef struct packed {
    logic       stall_if;
    logic       stall_id;
    logic       flush_id;
    logic       flush_ex;
    logic       fpu_issue;
    logic       fpu_done;
    logic [4:0] fpu_rd;
  } out_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_uses_rs1, id_uses_rs2, id_rd_we, id_is_fpu;
  logic [4:0] id_rs1, id_rs2, id_rd, ex_rd;
  logic [2:0] id_fpu_lat;
  logic       ex_is_load, branch_taken;
  logic       stall_if, stall_id, flush_id, flush_ex, fpu_issue, fpu_done;
  logic [4:0] fpu_rd;

  hazard_unit #(.FLUSH_DEPTH(FLUSH_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_fpu(id_is_fpu), .id_fpu_lat(id_fpu_lat),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .flush_ex(flush_ex),
    .fpu_issue(fpu_issue), .fpu_done(fpu_done), .fpu_rd(fpu_rd)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  out_t exp_q[$];

  // Reference model: the in-flight op is described by its completion cycle, the
  // flush window by the cycle of the most recent taken branch.
  int         cyc = 0;
  bit         op_valid;
  int         op_done_cyc;
  logic [4:0] op_rd;
  logic [4:0] last_rd;
  int         br_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic out_t dut_outs();
    return {stall_if, stall_id, flush_id, flush_ex, fpu_issue, fpu_done, fpu_rd};
  endfunction

  function automatic bit is_pending(input logic [4:0] r);
    return (r != 5'd0) && op_valid && (cyc <= op_done_cyc) && (r == op_rd);
  endfunction

  task automatic model_reset();
    op_valid    = 1'b0;
    op_done_cyc = 0;
    op_rd       = '0;
    last_rd     = '0;
    br_cyc      = -1000;
  endtask

  task automatic model_step(input stim_t s, output out_t e);
    bit lu, raw, waw, strct, fl, stl, iss, dn, free;
    int lat_eff;
    fl    = s.br || (cyc - br_cyc < FLUSH_DEPTH);
    lu    = s.ex_is_load && (s.ex_rd != 0) && s.id_valid &&
            ((s.use1 && s.rs1 == s.ex_rd) || (s.use2 && s.rs2 == s.ex_rd));
    raw   = s.id_valid && ((s.use1 && is_pending(s.rs1)) || (s.use2 && is_pending(s.rs2)));
    waw   = s.id_valid && s.rd_we && (s.rd != 0) && is_pending(s.rd);
    free  = !op_valid || (cyc >= op_done_cyc);
    strct = s.id_valid && s.is_fpu && !free;
    stl   = (lu || raw || waw || strct) && !fl;
    iss   = s.id_valid && s.is_fpu && free && !stl && !fl;
    dn    = op_valid && (cyc == op_done_cyc);
    e     = {stl, stl, fl, stl || s.br, iss, dn, last_rd};
    if (dn) op_valid = 1'b0;
    if (iss) begin
      lat_eff     = (s.lat == 0) ? 1 : int'(s.lat);
      op_valid    = 1'b1;
      op_done_cyc = cyc + lat_eff;
      op_rd       = s.rd;
      last_rd     = s.rd;
    end
    if (s.br) br_cyc = cyc;
  endtask

  task automatic apply(input stim_t s);
    id_valid = s.id_valid; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_uses_rs1 = s.use1; id_uses_rs2 = s.use2; id_rd = s.rd; id_rd_we = s.rd_we;
    id_is_fpu = s.is_fpu; id_fpu_lat = s.lat; ex_is_load = s.ex_is_load;
    ex_rd = s.ex_rd; branch_taken = s.br;
  endtask

  task automatic step(input stim_t s);
    out_t e;
    rst_n = 1'b1;
    apply(s);
    model_step(s, e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic reset_step(input stim_t s);
    apply(s);
    rst_n = 1'b0;
    #1;
    check("outputs_low_in_reset", 32'(dut_outs()), 32'(out_t'('0)));
    model_reset();
    exp_q.push_back('0);
    @(posedge clk); #1;
    cyc++;
  endtask

  function automatic stim_t fpu_op(input logic [4:0] rd, input logic [2:0] lat,
                                   input logic [4:0] rs1, input logic [4:0] rs2);
    stim_t s = '0;
    s.id_valid = 1'b1; s.is_fpu = 1'b1; s.rd = rd; s.rd_we = 1'b1; s.lat = lat;
    s.rs1 = rs1; s.rs2 = rs2; s.use1 = 1'b1; s.use2 = 1'b1;
    return s;
  endfunction

  function automatic stim_t alu_op(input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [4:0] rd);
    stim_t s = '0;
    s.id_valid = 1'b1; s.rs1 = rs1; s.rs2 = rs2; s.use1 = 1'b1; s.use2 = 1'b1;
    s.rd = rd; s.rd_we = 1'b1;
    return s;
  endfunction

  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("outputs{sif,sid,fid,fex,iss,done,rd}", 32'(dut_outs()), 32'(e));
      end
    end
  end

  initial begin
    stim_t s;
    model_reset();

    // Reset with hazard-provoking inputs: outputs must stay low.
    s = alu_op(5'd5, 5'd0, 5'd3);
    s.ex_is_load = 1'b1; s.ex_rd = 5'd5; s.br = 1'b1; s.is_fpu = 1'b1;
    apply(s);
    rst_n = 1'b0;
    #1;
    check("reset_outputs", 32'(dut_outs()), 32'(out_t'('0)));
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs_held", 32'(dut_outs()), 32'(out_t'('0)));

    // Load-use with a real register, then with x0.
    s = alu_op(5'd5, 5'd1, 5'd3); s.use2 = 1'b0; s.ex_is_load = 1'b1; s.ex_rd = 5'd5;
    step(s);
    s.ex_rd = 5'd0; s.rs1 = 5'd0;
    step(s);
    step('0);

    // FPU RAW: issue x7 lat 3, consumer reads x7 for four cycles.
    step(fpu_op(5'd7, 3'd3, 5'd1, 5'd2));
    repeat (4) step(alu_op(5'd7, 5'd1, 5'd4));
    step('0);

    // Structural: second FPU op waits, issues in the done cycle.
    step(fpu_op(5'd7, 3'd3, 5'd1, 5'd2));
    repeat (3) step(fpu_op(5'd9, 3'd2, 5'd1, 5'd2));
    repeat (3) step(alu_op(5'd9, 5'd0, 5'd4));

    // Same-rd back-to-back issue in the done cycle: pending must survive.
    step(fpu_op(5'd7, 3'd1, 5'd1, 5'd2));
    s = fpu_op(5'd7, 3'd2, 5'd1, 5'd2); s.rd_we = 1'b0;
    step(s);
    repeat (3) step(alu_op(5'd7, 5'd0, 5'd4));

    // FPU op to x0 still occupies the unit; latency 0 behaves as 1.
    step(fpu_op(5'd0, 3'd0, 5'd1, 5'd2));
    repeat (2) step(fpu_op(5'd0, 3'd2, 5'd1, 5'd2));
    repeat (2) step('0);

    // Branch while load-use and an FPU candidate are present.
    s = fpu_op(5'd6, 3'd2, 5'd5, 5'd1); s.ex_is_load = 1'b1; s.ex_rd = 5'd5; s.br = 1'b1;
    step(s);
    s.br = 1'b0;
    step(s);
    step(s);
    repeat (3) step('0);

    // Branch does not cancel an in-flight op.
    step(fpu_op(5'd8, 3'd3, 5'd1, 5'd2));
    s = '0; s.br = 1'b1;
    step(s);
    repeat (4) step(alu_op(5'd8, 5'd0, 5'd4));

    // Reset mid-operation: no done may follow, x11 no longer pending.
    step(fpu_op(5'd11, 3'd5, 5'd1, 5'd2));
    s = alu_op(5'd11, 5'd0, 5'd4); s.br = 1'b1;
    reset_step(s);
    reset_step(s);
    s.br = 1'b0;
    repeat (7) step(s);

    // Randomized traffic on a small register window to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      s.id_valid   = ($urandom_range(0, 9) != 0);
      s.rs1        = 5'($urandom_range(0, 7));
      s.rs2        = 5'($urandom_range(0, 7));
      s.use1       = 1'($urandom);
      s.use2       = 1'($urandom);
      s.rd         = 5'($urandom_range(0, 7));
      s.rd_we      = 1'($urandom);
      s.is_fpu     = ($urandom_range(0, 2) == 0);
      s.lat        = 3'($urandom);
      s.ex_is_load = ($urandom_range(0, 2) == 0);
      s.ex_rd      = 5'($urandom_range(0, 7));
      s.br         = ($urandom_range(0, 11) == 0);
      if (i % 200 == 199) reset_step(s);
      else step(s);
    end

    for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
